// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: memory word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM handshake reported by the memory model.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // One-hot arbiter states; any other pattern is treated as illegal.
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    GRANT_I = 3'b010,
    GRANT_D = 3'b100
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins by default; a waiting fetch is forced through after DSTREAK_MAX
// consecutive data completions. Grant outputs are combinational so that a
// RAM ACCESS response completes the requester in the same cycle.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned RAM_ERR_W   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 iREN,
  input  word_t                iaddr,
  input  logic                 dREN,
  input  logic                 dWEN,
  input  word_t                daddr,
  input  word_t                dstore,
  output logic                 iwait,
  output logic                 dwait,
  output word_t                iload,
  output word_t                dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic [RAM_ERR_W-1:0] err_cnt
);

  localparam int unsigned STREAK_W = (DSTREAK_MAX > 0) ? $clog2(DSTREAK_MAX + 1) : 1;

  arb_state_t           r_state;
  arb_state_t           w_next_state;
  logic [STREAK_W-1:0]  r_dstreak;
  logic [RAM_ERR_W-1:0] r_err_cnt;

  logic w_dreq;
  logic w_streak_at_max;
  logic w_i_done;
  logic w_d_done;
  logic w_err_hit;

  assign w_dreq          = dREN | dWEN;
  assign w_streak_at_max = (r_dstreak == STREAK_W'(DSTREAK_MAX));
  assign err_cnt         = r_err_cnt;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and grant outputs; while RST is high the idle view is shown
  // so an aborted access can never produce a completion.
  always_comb begin
    w_next_state = r_state;
    iwait        = iREN;
    dwait        = w_dreq;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    w_i_done     = 1'b0;
    w_d_done     = 1'b0;
    w_err_hit    = 1'b0;

    if (!RST) begin
      case (r_state)
        IDLE: begin
          if (w_dreq && !(iREN && w_streak_at_max)) begin
            w_next_state = GRANT_D;
          end else if (iREN) begin
            w_next_state = GRANT_I;
          end
        end

        GRANT_I: begin
          if (!iREN) begin
            w_next_state = IDLE;
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            case (ramstate)
              ACCESS: begin
                iwait        = 1'b0;
                iload        = ramload;
                w_i_done     = 1'b1;
                w_next_state = IDLE;
              end
              ERROR:   w_err_hit = 1'b1;
              default: ;
            endcase
          end
        end

        GRANT_D: begin
          if (!w_dreq) begin
            w_next_state = IDLE;
          end else begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = ~dWEN;
            case (ramstate)
              ACCESS: begin
                dwait        = 1'b0;
                dload        = dWEN ? '0 : ramload;
                w_d_done     = 1'b1;
                w_next_state = IDLE;
              end
              ERROR:   w_err_hit = 1'b1;
              default: ;
            endcase
          end
        end

        default: w_next_state = IDLE;
      endcase
    end
  end

  // Consecutive data completions seen while a fetch is waiting.
  always_ff @(posedge CLK) begin
    if (RST || !iREN || w_i_done) begin
      r_dstreak <= '0;
    end else if (w_d_done && !w_streak_at_max) begin
      r_dstreak <= r_dstreak + STREAK_W'(1);
    end
  end

  // Saturating count of RAM ERROR responses on a live grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err_cnt <= '0;
    end else if (w_err_hit && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + RAM_ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run scored
// against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned DMAX   = 4;
  localparam int unsigned EW     = 4;
  localparam int          ERRMAX = (1 << EW) - 1;

  logic          CLK;
  logic          RST;
  logic          iREN, dREN, dWEN;
  word_t         iaddr, daddr, dstore, ramload;
  ramstate_t     ramstate;
  logic          iwait, dwait, ramREN, ramWEN;
  word_t         iload, dload, ramaddr, ramstore;
  logic [EW-1:0] err_cnt;

  mem_arbiter #(.DSTREAK_MAX(DMAX), .RAM_ERR_W(EW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_cnt(err_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic clear_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ramstate = FREE;
  endtask

  function automatic ramstate_t pick_rs();
    int unsigned r;
    r = $urandom_range(9, 0);
    if (r < 4)      return ACCESS;
    else if (r < 6) return FREE;
    else if (r < 8) return BUSY;
    else            return ERROR;
  endfunction

  // Reference model: who currently owns the RAM (0 none, 1 fetch, 2 data),
  // how many data completions in a row a waiting fetch has sat through, and
  // how many RAM errors have been seen.
  int    m_own, m_streak, m_err;
  int    n_own, n_streak, n_err;
  logic  e_iwait, e_dwait, e_rren, e_rwen, e_icomp, e_dcomp;
  word_t e_iload, e_dload, e_raddr, e_rstore;

  task automatic model_eval();
    logic dreq;
    logic granted_err;
    dreq        = dREN | dWEN;
    granted_err = 1'b0;
    e_iwait = iREN;  e_dwait = dreq;
    e_rren  = 1'b0;  e_rwen  = 1'b0;
    e_raddr = '0;    e_rstore = '0;
    e_iload = '0;    e_dload  = '0;
    e_icomp = 1'b0;  e_dcomp  = 1'b0;
    n_own   = m_own;
    if (RST) begin
      n_own = 0; n_streak = 0; n_err = 0;
      return;
    end
    if (m_own == 0) begin
      if (dreq && !(iREN && m_streak == int'(DMAX))) n_own = 2;
      else if (iREN)                                 n_own = 1;
    end else if (m_own == 1) begin
      if (!iREN) n_own = 0;
      else begin
        e_rren  = 1'b1;
        e_raddr = iaddr;
        if (ramstate == ACCESS) begin
          e_icomp = 1'b1; e_iwait = 1'b0; e_iload = ramload; n_own = 0;
        end
        granted_err = (ramstate == ERROR);
      end
    end else begin
      if (!dreq) n_own = 0;
      else begin
        e_raddr  = daddr;
        e_rstore = dstore;
        if (dWEN) e_rwen = 1'b1;
        else      e_rren = 1'b1;
        if (ramstate == ACCESS) begin
          e_dcomp = 1'b1; e_dwait = 1'b0; n_own = 0;
          if (!dWEN) e_dload = ramload;
        end
        granted_err = (ramstate == ERROR);
      end
    end
    if (!iREN || e_icomp) n_streak = 0;
    else if (e_dcomp)     n_streak = (m_streak + 1 > int'(DMAX)) ? int'(DMAX) : m_streak + 1;
    else                  n_streak = m_streak;
    n_err = (granted_err && m_err < ERRMAX) ? m_err + 1 : m_err;
  endtask

  int          cnt_a, cnt_b, cnt_c;
  int          first_d, first_i, ncomp;
  word_t       got_load;
  logic [15:0] seq;
  logic        prev_ic, prev_dc;

  initial begin
    clear_inputs();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK); #2;
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge CLK); RST = 1'b0; #2;
    check("idle_iwait", 32'(iwait), 32'd0);
    check("idle_dwait", 32'(dwait), 32'd0);

    // Fetch with two busy cycles then ACCESS.
    cnt_a = 0; cnt_b = 0; got_load = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      iREN = (c < 5); iaddr = 32'h40; ramload = 32'hDEADBEEF;
      ramstate = (c == 3) ? ACCESS : BUSY;
      #2;
      if (ramREN) cnt_a++;
      if (iREN && !iwait) begin cnt_b++; got_load = iload; end
      if (c == 0) check("f_idle_iwait", 32'(iwait), 32'd1);
      if (c == 1) check("f_ramaddr", ramaddr, 32'h40);
      if (c == 2) check("f_iload_idle", iload, 32'd0);
    end
    check("f_ramREN_cycles", 32'(cnt_a), 32'd3);
    check("f_iwait_low", 32'(cnt_b), 32'd1);
    check("f_iload", got_load, 32'hDEADBEEF);

    // Simultaneous requests: data first, then the fetch.
    first_d = -1; first_i = -1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      iREN = (c < 4); dREN = (c < 2); iaddr = 32'h200; daddr = 32'h100;
      ramstate = ACCESS;
      #2;
      if (dREN && !dwait && first_d < 0) first_d = c;
      if (iREN && !iwait && first_i < 0) first_i = c;
      if (c == 1) check("p_daddr", ramaddr, 32'h100);
      if (c == 3) check("p_iaddr", ramaddr, 32'h200);
    end
    check("p_d_first", 32'(first_d), 32'd1);
    check("p_i_second", 32'(first_i), 32'd3);

    // Data streak fairness: four data completions then one fetch, repeating.
    seq = '0; ncomp = 0; cnt_a = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      iREN = 1'b1; dREN = 1'b1; ramstate = ACCESS;
      #2;
      if (!iwait && ncomp < 16) begin seq[ncomp] = 1'b1; ncomp++; end
      else if (!dwait && ncomp < 16) begin ncomp++; cnt_a++; end
    end
    check("s_completions", 32'(ncomp), 32'd10);
    check("s_data_count", 32'(cnt_a), 32'd8);
    check("s_order", 32'(seq), 32'h210);
    @(negedge CLK); clear_inputs(); #2;

    // Write with two ERROR retries.
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      dWEN = (c < 4); daddr = 32'h80; dstore = 32'h12345678;
      ramstate = (c == 3) ? ACCESS : ERROR;
      #2;
      if (ramWEN) cnt_a++;
      if (ramREN) cnt_b++;
      if (dWEN && !dwait) cnt_c++;
      if (c == 1) check("w_ramstore", ramstore, 32'h12345678);
      if (c == 4) check("w_err_cnt", 32'(err_cnt), 32'd2);
    end
    check("w_ramWEN_cycles", 32'(cnt_a), 32'd3);
    check("w_ramREN_cycles", 32'(cnt_b), 32'd0);
    check("w_dwait_pulses", 32'(cnt_c), 32'd1);

    // Reset mid-grant while BUSY.
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      dREN = (c < 4); daddr = 32'h100;
      RST = (c == 2);
      ramstate = (c < 2) ? BUSY : ACCESS;
      #2;
      if (c == 1) check("r_granted", 32'(ramREN), 32'd1);
      if (c == 2) check("r_no_pulse_rst", 32'(dwait), 32'd1);
      if (c == 3) begin
        check("r_after_ren", 32'(ramREN), 32'd0);
        check("r_after_wen", 32'(ramWEN), 32'd0);
        check("r_after_dwait", 32'(dwait), 32'd1);
        check("r_after_err", 32'(err_cnt), 32'd0);
      end
    end
    RST = 1'b0;

    // Data request dropped mid-grant; the pending fetch follows.
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      iREN = (c < 5); dREN = (c < 2); iaddr = 32'h300; daddr = 32'h104;
      ramstate = BUSY;
      #2;
      if (c == 1) check("x_granted", 32'(ramREN), 32'd1);
      if (c == 2) begin
        check("x_drop_ren", 32'(ramREN), 32'd0);
        check("x_drop_dwait", 32'(dwait), 32'd0);
        check("x_drop_iwait", 32'(iwait), 32'd1);
      end
      if (c == 3) check("x_idle_ren", 32'(ramREN), 32'd0);
      if (c == 4) begin
        check("x_fetch_ren", 32'(ramREN), 32'd1);
        check("x_fetch_addr", ramaddr, 32'h300);
      end
    end

    // Randomized run against the reference model.
    @(negedge CLK); clear_inputs(); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    m_own = 0; m_streak = 0; m_err = 0;
    prev_ic = 1'b0; prev_dc = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge CLK);
      if (iREN) begin
        if (prev_ic) begin
          if ($urandom_range(1, 0) == 1) iaddr = $urandom;
          else iREN = 1'b0;
        end else if ($urandom_range(29, 0) == 0) iREN = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        iREN = 1'b1; iaddr = $urandom;
      end
      if (dREN | dWEN) begin
        if (prev_dc || $urandom_range(29, 0) == 0) begin
          dREN = 1'b0; dWEN = 1'b0;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        dREN = $urandom_range(1, 0) == 1;
        dWEN = !dREN || ($urandom_range(9, 0) == 0);
        daddr = $urandom; dstore = $urandom;
      end
      RST      = ($urandom_range(99, 0) == 0);
      ramstate = pick_rs();
      ramload  = $urandom;
      #2;
      model_eval();
      check("m_iwait", 32'(iwait), 32'(e_iwait));
      check("m_dwait", 32'(dwait), 32'(e_dwait));
      check("m_iload", iload, e_iload);
      check("m_dload", dload, e_dload);
      check("m_ramREN", 32'(ramREN), 32'(e_rren));
      check("m_ramWEN", 32'(ramWEN), 32'(e_rwen));
      check("m_ramaddr", ramaddr, e_raddr);
      check("m_ramstore", ramstore, e_rstore);
      check("m_err_cnt", 32'(err_cnt), 32'(m_err));
      m_own = n_own; m_streak = n_streak; m_err = n_err;
      prev_ic = e_icomp; prev_dc = e_dcomp;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DSTREAK_MAX, default 4, max consecutive data grants while an instruction request waits.
REQ-002 Parameter: RAM_ERR_W, default 8, width of the saturating RAM-error counter.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 iREN  in  1  instruction fetch request from datapath/icache.
REQ-006 iaddr  in  32  fetch word address (word_t); held stable while iREN and iwait are high.
REQ-007 dREN  in  1  data read request.
REQ-008 dWEN  in  1  data write request.
REQ-009 daddr  in  32  data address; held stable while the request is pending.
REQ-010 dstore  in  32  write data.
REQ-011 iwait  out  1  high = fetch not complete.
REQ-012 dwait  out  1  high = data access not complete.
REQ-013 iload  out  32  fetched word; valid in the cycle iwait is low with iREN high.
REQ-014 dload  out  32  read word; valid in the cycle dwait is low with dREN high.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
REQ-021 err_cnt  out  RAM_ERR_W  count of ERROR responses, saturating at all-ones.

Function
REQ-022 FSM states IDLE, GRANT_I, GRANT_D; one-hot-safe encoding, illegal state returns to IDLE.
REQ-023 IDLE: RAM strobes low; iwait = iREN; dwait = dREN|dWEN.
REQ-024 IDLE transition: if (dREN|dWEN) and not (iREN and dstreak==DSTREAK_MAX) -> GRANT_D; else if iREN -> GRANT_I; else stay.
REQ-025 GRANT_D: ramaddr=daddr, ramstore=dstore; dWEN high -> ramWEN=1, ramREN=0; else ramREN=1; dWEN wins when both asserted.
REQ-026 GRANT_I: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-027 In grant state, ramstate==ACCESS -> granted wait low that same cycle, load = ramload combinationally, next state IDLE; other wait stays high if its request is up.
REQ-028 ramstate FREE/BUSY -> hold grant, wait high.
REQ-029 ramstate ERROR -> hold grant, wait high, retry next cycle, err_cnt += 1 unless saturated.
REQ-030 Requester drops its request mid-grant -> strobes low that cycle, return to IDLE, no wait pulse, no streak update.
REQ-031 dstreak counter: +1 (saturating at DSTREAK_MAX) on each completed data access while iREN high; cleared on completed fetch or any cycle iREN low.
REQ-032 Latency: request first seen in IDLE cycle n; RAM strobes from cycle n+1; completion earliest cycle n+1; back-to-back accesses at most one every 2 cycles.
REQ-033 iload/dload = 0 when not completing.

Reset
REQ-034 RST high at a clock edge: state IDLE, dstreak 0, err_cnt 0; outputs then follow IDLE rules (strobes 0, ramaddr 0).
REQ-035 RST mid-grant aborts the access; no wait pulse generated during or after reset cycle.

Structure
REQ-036 ramstate_t and word_t come from cpu_types_pkg; arb_state_t enum is added to cpu_types_pkg.
REQ-037 Single module; dstreak and err_cnt are inline counters; no sub-module.

Verification
REQ-038 iREN only, iaddr=0x40, ramstate ACCESS 3 cycles after grant, ramload=0xDEADBEEF -> ramREN high 3 cycles, iwait low 1 cycle, iload=0xDEADBEEF.
REQ-039 iREN and dREN same cycle, daddr=0x100 -> GRANT_D first, dwait low before iwait; fetch serviced next.
REQ-040 iREN held, dREN/dWEN continuous, DSTREAK_MAX=4 -> exactly 4 data completions, then one fetch, repeat.
REQ-041 dWEN with dstore=0x12345678, two ERROR cycles then ACCESS -> ramWEN held, err_cnt=2, single dwait-low pulse.
REQ-042 RST asserted during GRANT_D while BUSY -> next cycle IDLE, strobes 0, err_cnt 0, no dwait pulse.
REQ-043 dREN dropped mid-grant -> ramREN low same cycle, IDLE next, pending iREN then granted.
